// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the micro-sequencer and its control store:
// microinstruction field layout, address width and sequencer state encoding.
package micro_sequencer_pkg;

    localparam int ADDR_W   = 9;
    localparam int MIR_W    = 36;
    localparam int REG_WE_W = 9;
    localparam int FIELD_W  = 4;
    localparam int COUNT_W  = 16;

    localparam int MIR_NEXT_LSB    = 27;
    localparam int MIR_REG_WE_LSB  = 18;
    localparam int MIR_WR_SEL_LSB  = 14;
    localparam int MIR_MEM_WR_BIT  = 13;
    localparam int MIR_PC_INC_BIT  = 12;
    localparam int MIR_MEM_RD_BIT  = 11;
    localparam int MIR_ALU_OP_LSB  = 7;
    localparam int MIR_BUS_SEL_LSB = 3;
    localparam int MIR_HALT_BIT    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   next;
        logic [REG_WE_W-1:0] reg_we;
        logic [FIELD_W-1:0]  wr_sel;
        logic                mem_wr;
        logic                pc_inc;
        logic                mem_rd;
        logic [FIELD_W-1:0]  alu_op;
        logic [FIELD_W-1:0]  bus_sel;
        logic                halt;
    } mir_t;

endpackage

// File: rtl/micro_sequencer_stall_timer.sv
// Memory stall counter: cleared when a memory step first stalls, counts
// stall cycles and flags the last permitted stall cycle.
module seq_stall_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Stall-cycle counter, saturating at TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != CW'(TIMEOUT))) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign hit = enable && (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: walks the control store, issues the datapath
// strobes of each microinstruction and stretches memory steps until ready.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MIR_W-1:0]    mir,
    input  logic                start,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   addr,
    output logic [REG_WE_W-1:0] reg_we,
    output logic [FIELD_W-1:0]  wr_sel,
    output logic                mem_wr,
    output logic                mem_rd,
    output logic                pc_inc,
    output logic [FIELD_W-1:0]  alu_op,
    output logic [FIELD_W-1:0]  bus_sel,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err,
    output logic [COUNT_W-1:0]  instr_count
);

    seq_state_e          state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [COUNT_W-1:0]  instr_count_r;
    logic                busy_r;
    logic                halted_r;
    logic                timeout_err_r;

    mir_t                mir_s;
    logic                mir_unused_s;
    logic                mem_op_s;
    logic                step_done_s;
    logic                stall_enter_s;
    logic                in_stall_s;
    logic                timer_hit_s;
    logic                timed_out_s;
    logic                halt_step_s;
    logic                load_next_s;
    logic                count_step_s;

    assign mir_s.next    = mir[MIR_NEXT_LSB +: ADDR_W];
    assign mir_s.reg_we  = mir[MIR_REG_WE_LSB +: REG_WE_W];
    assign mir_s.wr_sel  = mir[MIR_WR_SEL_LSB +: FIELD_W];
    assign mir_s.mem_wr  = mir[MIR_MEM_WR_BIT];
    assign mir_s.pc_inc  = mir[MIR_PC_INC_BIT];
    assign mir_s.mem_rd  = mir[MIR_MEM_RD_BIT];
    assign mir_s.alu_op  = mir[MIR_ALU_OP_LSB +: FIELD_W];
    assign mir_s.bus_sel = mir[MIR_BUS_SEL_LSB +: FIELD_W];
    assign mir_s.halt    = mir[MIR_HALT_BIT];
    assign mir_unused_s  = ^mir[MIR_BUS_SEL_LSB-1:MIR_HALT_BIT+1];

    assign mem_op_s      = mir_s.mem_rd | mir_s.mem_wr;
    assign in_stall_s    = (state_r == ST_STALL);
    assign step_done_s   = ((state_r == ST_RUN) && (!mem_op_s || mem_ready)) ||
                           (in_stall_s && mem_ready);
    assign stall_enter_s = (state_r == ST_RUN) && mem_op_s && !mem_ready;
    assign timed_out_s   = in_stall_s && !mem_ready && timer_hit_s;
    assign halt_step_s   = step_done_s && mir_s.halt;
    assign load_next_s   = step_done_s && !mir_s.halt;
    // A macro-instruction ends when the microprogram jumps back to address 0.
    assign count_step_s  = load_next_s && (mir_s.next == {ADDR_W{1'b0}}) &&
                           (addr_r != {ADDR_W{1'b0}});

    seq_stall_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_stall_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (stall_enter_s),
        .enable (in_stall_s),
        .hit    (timer_hit_s)
    );

    // Sequencer FSM with its registered address, count and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            addr_r        <= {ADDR_W{1'b0}};
            instr_count_r <= {COUNT_W{1'b0}};
            busy_r        <= 1'b0;
            halted_r      <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (timed_out_s || halt_step_s) begin
                        state_r  <= ST_HALT;
                        busy_r   <= 1'b0;
                        halted_r <= 1'b1;
                        if (timed_out_s) begin
                            timeout_err_r <= 1'b1;
                        end
                    end else if (load_next_s) begin
                        state_r <= ST_RUN;
                        addr_r  <= mir_s.next;
                        if (count_step_s) begin
                            instr_count_r <= instr_count_r + 16'd1;
                        end
                    end else if (stall_enter_s) begin
                        state_r <= ST_STALL;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HALT: begin
                    if (start) begin
                        state_r  <= ST_RUN;
                        addr_r   <= {ADDR_W{1'b0}};
                        busy_r   <= 1'b1;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // Strobes follow the microinstruction within the cycle it is presented;
    // a pending memory step holds back everything that would commit state.
    always_comb begin
        reg_we  = {REG_WE_W{1'b0}};
        wr_sel  = {FIELD_W{1'b0}};
        mem_wr  = 1'b0;
        mem_rd  = 1'b0;
        pc_inc  = 1'b0;
        alu_op  = {FIELD_W{1'b0}};
        bus_sel = {FIELD_W{1'b0}};
        case (state_r)
            ST_RUN: begin
                mem_wr  = mir_s.mem_wr;
                mem_rd  = mir_s.mem_rd;
                wr_sel  = mir_s.wr_sel;
                bus_sel = mir_s.bus_sel;
                if (step_done_s) begin
                    reg_we = mir_s.reg_we;
                    pc_inc = mir_s.pc_inc;
                    alu_op = mir_s.alu_op;
                end else begin
                    reg_we = {REG_WE_W{1'b0}};
                    pc_inc = 1'b0;
                    alu_op = {FIELD_W{1'b0}};
                end
            end
            ST_STALL: begin
                mem_wr = mir_s.mem_wr;
                mem_rd = mir_s.mem_rd;
                if (mem_ready) begin
                    reg_we  = mir_s.reg_we;
                    pc_inc  = mir_s.pc_inc;
                    alu_op  = mir_s.alu_op;
                    wr_sel  = mir_s.wr_sel;
                    bus_sel = mir_s.bus_sel;
                end else begin
                    reg_we  = {REG_WE_W{1'b0}};
                    pc_inc  = 1'b0;
                    alu_op  = {FIELD_W{1'b0}};
                    wr_sel  = {FIELD_W{1'b0}};
                    bus_sel = {FIELD_W{1'b0}};
                end
            end
            default: begin
                mem_wr = 1'b0;
                mem_rd = 1'b0;
            end
        endcase
    end

    assign addr        = addr_r;
    assign instr_count = instr_count_r;
    assign busy        = busy_r;
    assign halted      = halted_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios followed by a
// random microprogram, all compared against a behavioural model.
module tb_micro_sequencer;

    localparam int MEM_TIMEOUT = 15;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STALL = 2;
    localparam int M_HALT  = 3;

    logic        clk;
    logic        rst;
    logic [35:0] mir;
    logic        start;
    logic        mem_ready;
    logic [8:0]  addr;
    logic [8:0]  reg_we;
    logic [3:0]  wr_sel;
    logic        mem_wr;
    logic        mem_rd;
    logic        pc_inc;
    logic [3:0]  alu_op;
    logic [3:0]  bus_sel;
    logic        busy;
    logic        halted;
    logic        timeout_err;
    logic [15:0] instr_count;
    logic [23:0] obs_str;

    int          n_checks;
    int          n_errors;

    int          m_mode;
    logic [8:0]  m_addr;
    logic [15:0] m_cnt;
    int          m_stalls;
    logic        m_terr;

    logic [35:0] rom [512];

    micro_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .mir         (mir),
        .start       (start),
        .mem_ready   (mem_ready),
        .addr        (addr),
        .reg_we      (reg_we),
        .wr_sel      (wr_sel),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .pc_inc      (pc_inc),
        .alu_op      (alu_op),
        .bus_sel     (bus_sel),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .instr_count (instr_count)
    );

    assign obs_str = {reg_we, wr_sel, mem_wr, mem_rd, pc_inc, alu_op, bus_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [8:0] nxt, input logic [8:0] we,
                                       input logic [3:0] ws, input logic mw, input logic pc,
                                       input logic mr, input logic [3:0] alu,
                                       input logic [3:0] bs, input logic h);
        return {nxt, we, ws, mw, pc, mr, alu, bs, 2'b00, h};
    endfunction

    // Expected strobe bundle {reg_we, wr_sel, mem_wr, mem_rd, pc_inc, alu_op, bus_sel}.
    function automatic logic [23:0] model_strobes(input logic [35:0] w, input logic rdy);
        logic done;
        logic [23:0] s;
        s = 24'h0;
        done = !(w[13] | w[11]) || rdy;
        if (m_mode == M_RUN) begin
            s = {done ? w[26:18] : 9'h000, w[17:14], w[13], w[11],
                 done ? w[12] : 1'b0, done ? w[10:7] : 4'h0, w[6:3]};
        end else if (m_mode == M_STALL) begin
            s = rdy ? {w[26:18], w[17:14], w[13], w[11], w[12], w[10:7], w[6:3]}
                    : {9'h000, 4'h0, w[13], w[11], 1'b0, 4'h0, 4'h0};
        end
        return s;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_addr   = 9'h000;
        m_cnt    = 16'h0000;
        m_stalls = 0;
        m_terr   = 1'b0;
    endtask

    task automatic model_finish(input logic [35:0] w);
        if (w[0]) begin
            m_mode = M_HALT;
        end else begin
            if (w[35:27] == 9'h000 && m_addr != 9'h000) m_cnt = m_cnt + 16'd1;
            m_addr = w[35:27];
            m_mode = M_RUN;
        end
    endtask

    task automatic model_advance(input logic [35:0] w, input logic s, input logic rdy);
        case (m_mode)
            M_IDLE: if (s) m_mode = M_RUN;
            M_RUN: begin
                if (!(w[13] | w[11]) || rdy) model_finish(w);
                else begin
                    m_mode   = M_STALL;
                    m_stalls = 0;
                end
            end
            M_STALL: begin
                if (rdy) model_finish(w);
                else begin
                    m_stalls++;
                    if (m_stalls == MEM_TIMEOUT) begin
                        m_mode = M_HALT;
                        m_terr = 1'b1;
                    end
                end
            end
            M_HALT: begin
                if (s) begin
                    m_mode = M_RUN;
                    m_addr = 9'h000;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // One clock cycle: drive on the falling edge, check strobes, then check state.
    task automatic step(input logic [35:0] w, input logic s, input logic rdy);
        @(negedge clk);
        mir = w;
        start = s;
        mem_ready = rdy;
        #1;
        chk("strobes", obs_str, model_strobes(w, rdy));
        model_advance(w, s, rdy);
        @(posedge clk);
        #1;
        chk("addr", addr, m_addr);
        chk("busy", busy, (m_mode == M_RUN) || (m_mode == M_STALL));
        chk("halted", halted, m_mode == M_HALT);
        chk("timeout_err", timeout_err, m_terr);
        chk("instr_count", instr_count, m_cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mir = 36'h0;
        start = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_addr", addr, 9'h000);
        chk("rst_strobes", obs_str, 24'h0);
        chk("rst_flags", {busy, halted, timeout_err}, 3'b000);
        chk("rst_count", instr_count, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [35:0] w;
        logic        rdy;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        mir = 36'h0;
        start = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        do_reset();

        // Scenario 1: start, then a plain step to address 1.
        step(mk(9'd1, 9'h010, 4'h2, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4, 1'b0), 1'b1, 1'b0);
        step(mk(9'd1, 9'h010, 4'h2, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4, 1'b0), 1'b0, 1'b0);
        chk("s1_addr", addr, 9'd1);
        chk("s1_busy", busy, 1'b1);

        // Scenario 2: memory read stalled for three cycles.
        w = mk(9'd5, 9'h001, 4'h6, 1'b0, 1'b1, 1'b1, 4'h9, 4'hA, 1'b0);
        for (int i = 0; i < 4; i++) step(w, 1'b1, (i == 3));
        chk("s2_addr", addr, 9'd5);

        // Scenario 3: memory never ready.
        w = mk(9'd7, 9'h1FF, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(w, 1'b0, 1'b0);
        chk("s3_timeout", timeout_err, 1'b1);
        chk("s3_halted", halted, 1'b1);
        step(w, 1'b0, 1'b0);
        chk("s3_strobes", obs_str, 24'h0);

        // Scenario 4: resume, advance, halt on a microinstruction, resume.
        step(mk(9'd3, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b1, 1'b0);
        chk("s4_resume_addr", addr, 9'd0);
        step(mk(9'd3, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(mk(9'h1AB, 9'h0F0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h7, 1'b1), 1'b0, 1'b0);
        chk("s4_hold_addr", addr, 9'd3);
        chk("s4_halted", halted, 1'b1);
        step(mk(9'd2, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b1, 1'b0);
        chk("s4_restart_addr", addr, 9'd0);
        chk("s4_sticky_timeout", timeout_err, 1'b1);

        // Scenario 5: macro-instruction counting and wrap.
        do_reset();
        step(mk(9'd2, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(mk(9'(2 * i), 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b0, 1'b0);
            step(mk(9'd0, 9'h003, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0), 1'b0, 1'b0);
        end
        chk("s5_count3", instr_count, 16'd3);
        @(negedge clk);
        force dut.instr_count_r = 16'hFFFF;
        #1;
        release dut.instr_count_r;
        m_cnt = 16'hFFFF;
        chk("s5_preload", instr_count, 16'hFFFF);
        step(mk(9'd7, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b0, 1'b0);
        step(mk(9'd0, 9'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0), 1'b0, 1'b0);
        chk("s5_wrap", instr_count, 16'h0000);

        // Scenario 6: reset in the middle of a stall.
        w = mk(9'd8, 9'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        step(w, 1'b0, 1'b0);
        step(w, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("s6_mem_rd", mem_rd, 1'b0);
        chk("s6_mem_wr", mem_wr, 1'b0);
        chk("s6_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_idle", {busy, halted, addr}, 11'h000);
        step(w, 1'b0, 1'b1);
        chk("s6_stays_idle", busy, 1'b0);

        // Random microprogram with random handshakes and stray starts.
        for (int i = 0; i < 512; i++) begin
            w = {4'($urandom), $urandom};
            w[35:27] = 9'($urandom_range(0, 31));
            w[0] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 0) begin
                w[13] = 1'b0;
                w[11] = 1'b0;
            end
            rom[i] = w;
        end
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rdy = ((i % 400) < 20) ? 1'b0 : ($urandom_range(0, 2) != 0);
            step(rom[m_addr], ($urandom_range(0, 7) == 0), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The module SHALL declare parameter MEM_TIMEOUT, default 15, meaning the maximum number of stall cycles allowed for one memory-access micro-step.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 mir  input  36  microinstruction from the control store; it updates on the falling clock edge.
REQ-005 start  input  1  level; begin execution from micro-address 0.
REQ-006 mem_ready  input  1  memory completion handshake.
REQ-007 addr  output  9  micro-address register fed back to the control store.
REQ-008 reg_we  output  9  register write enables, copy of mir[26:18].
REQ-009 wr_sel  output  4  destination select, copy of mir[17:14].
REQ-010 mem_wr / mem_rd  output  1 each  memory write (mir[13]) and memory read (mir[11]) requests.
REQ-011 pc_inc  output  1  PC increment strobe (mir[12]).
REQ-012 alu_op  output  4  copy of mir[10:7].
REQ-013 bus_sel  output  4  copy of mir[6:3].
REQ-014 busy, halted, timeout_err  output  1 each  status flags.
REQ-015 instr_count  output  16  count of completed macro-instructions.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, STALL, and HALT.
REQ-017 IDLE: all strobes are 0 and addr is 0; start=1 moves to RUN.
REQ-018 RUN without a memory op (mir[13]=0 and mir[11]=0): strobes SHALL equal their mir fields for exactly one cycle, and addr SHALL take mir[35:27] at the next rising edge.
REQ-019 RUN with a memory op and mem_ready=1: the step SHALL complete like REQ-018 in the same cycle.
REQ-020 RUN with a memory op and mem_ready=0: the FSM SHALL go to STALL; addr is held; reg_we, pc_inc, and alu_op are forced to 0; mem_rd and mem_wr are kept asserted.
REQ-021 STALL: mem_rd and mem_wr SHALL stay asserted and the other strobes stay 0.
REQ-022 When mem_ready=1 in STALL, reg_we, pc_inc, alu_op, wr_sel, and bus_sel SHALL be driven from mir for that cycle, addr SHALL load mir[35:27], and the FSM SHALL return to RUN.
REQ-023 The stall counter SHALL clear on entry to STALL and increment each STALL cycle; when it reaches MEM_TIMEOUT with mem_ready=0, timeout_err SHALL set (sticky), the FSM SHALL go to HALT, and all strobes SHALL drop.
REQ-024 When mir[0]=1 in RUN, the step's strobes SHALL issue, then the FSM SHALL enter HALT with halted=1 and addr held.
REQ-025 HALT with start=1: the FSM SHALL go to RUN with addr=0; timeout_err stays set until reset.
REQ-026 instr_count SHALL increment when a completing step loads addr with 0 from a nonzero addr; it wraps from 0xFFFF to 0.
REQ-027 busy SHALL be 1 in RUN and STALL.
REQ-028 start in RUN or STALL SHALL be ignored.
REQ-029 If mir[35:27] is X or Z when loaded, the design's responsibility is limited to loading the 9 bits as presented, with no detection.

Reset
REQ-030 While rst=1: state=IDLE; addr=0; instr_count=0; stall counter=0; timeout_err=0; halted=0; all strobes 0.
REQ-031 Assertion of rst mid-STALL SHALL immediately drop mem_rd and mem_wr.

Structure
REQ-032 MIR field bit positions, state encodings, and the 9-bit address width SHALL live in a shared package shared with the control store.
REQ-033 The stall counter with timeout compare SHALL be one sub-module, seq_stall_timer.

Verification
REQ-034 Scenario 1: reset, then start=1 with mir next=1 and no memory op -> addr=1 after one rising edge, busy=1.
REQ-035 Scenario 2: mir={next=5, reg_we=9'h001, mem_rd=1, pc_inc=1} with mem_ready low for 3 cycles -> mem_rd high 4 cycles, reg_we=0 for the first 3, reg_we=9'h001 and addr=5 on the 4th.
REQ-036 Scenario 3: mem_ready held 0 with MEM_TIMEOUT=15 -> timeout_err=1 and halted=1 after 15 stall cycles, all strobes 0.
REQ-037 Scenario 4: mir[0]=1 with next=X -> halted=1 and addr unchanged; then start=1 -> addr=0, RUN.
REQ-038 Scenario 5: three macro-instructions each ending with next=0 -> instr_count=3; preload 0xFFFF plus one completion -> 0.
REQ-039 Scenario 6: rst asserted during STALL -> mem_rd=0 combinationally, IDLE after release.
